// File: rtl/role_mem_arbiter.sv
// 2:1 round-robin AXI4 arbiter sharing one 256-bit memory master between two requesters.
// Requester index rides in the master ID MSB; W follows AW grant order via a small FIFO.

module role_mem_arbiter_addr #(
  parameter int ID_W = 13,
  parameter int P_W  = 73
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      valid,
  input  logic [ID_W-1:0] id0, id1,
  input  logic [P_W-1:0]  pay0, pay1,
  output logic [1:0]      ready,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [ID_W:0]   m_id,
  output logic [P_W-1:0]  m_pay
);
  logic full, ptr, gnt, take;

  assign gnt     = (&valid) ? ptr : valid[1];
  assign take    = en && (|valid) && (!full || m_ready);
  // Handshake outputs are forced low while reset is asserted, not just after the next edge.
  assign ready   = (rst_n && take) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign m_valid = full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      ptr  <= 1'b0;
    end else if (take) begin
      full <= 1'b1;
      ptr  <= !gnt;
    end else if (m_ready) begin
      full <= 1'b0;
    end
  end

  // NOTE: payload and FIFO storage carry no reset; the valid/count state alone qualifies them.
  always_ff @(posedge clk) begin
    if (take) begin
      m_id  <= {gnt, gnt ? id1 : id0};
      m_pay <= gnt ? pay1 : pay0;
    end
  end
endmodule

module role_mem_arbiter #(
  parameter int ID_W     = 13,
  parameter int ADDR_W   = 48,
  parameter int DATA_W   = 256,
  parameter int WQ_DEPTH = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     s0_axi_arid, s1_axi_arid, s0_axi_awid, s1_axi_awid,
  input  logic [ADDR_W-1:0]   s0_axi_araddr, s1_axi_araddr, s0_axi_awaddr, s1_axi_awaddr,
  input  logic [1:0]          s0_axi_arburst, s1_axi_arburst, s0_axi_awburst, s1_axi_awburst,
  input  logic [3:0]          s0_axi_arcache, s1_axi_arcache, s0_axi_awcache, s1_axi_awcache,
  input  logic [7:0]          s0_axi_arlen, s1_axi_arlen, s0_axi_awlen, s1_axi_awlen,
  input  logic                s0_axi_arlock, s1_axi_arlock, s0_axi_awlock, s1_axi_awlock,
  input  logic [2:0]          s0_axi_arprot, s1_axi_arprot, s0_axi_awprot, s1_axi_awprot,
  input  logic [3:0]          s0_axi_arqos, s1_axi_arqos, s0_axi_awqos, s1_axi_awqos,
  input  logic [2:0]          s0_axi_arsize, s1_axi_arsize, s0_axi_awsize, s1_axi_awsize,
  input  logic                s0_axi_arvalid, s1_axi_arvalid, s0_axi_awvalid, s1_axi_awvalid,
  output logic                s0_axi_arready, s1_axi_arready, s0_axi_awready, s1_axi_awready,
  input  logic [DATA_W-1:0]   s0_axi_wdata, s1_axi_wdata,
  input  logic [DATA_W/8-1:0] s0_axi_wstrb, s1_axi_wstrb,
  input  logic                s0_axi_wlast, s1_axi_wlast, s0_axi_wvalid, s1_axi_wvalid,
  output logic                s0_axi_wready, s1_axi_wready,
  output logic [ID_W-1:0]     s0_axi_rid, s1_axi_rid, s0_axi_bid, s1_axi_bid,
  output logic [DATA_W-1:0]   s0_axi_rdata, s1_axi_rdata,
  output logic [1:0]          s0_axi_rresp, s1_axi_rresp, s0_axi_bresp, s1_axi_bresp,
  output logic                s0_axi_rlast, s1_axi_rlast, s0_axi_rvalid, s1_axi_rvalid,
  input  logic                s0_axi_rready, s1_axi_rready,
  output logic                s0_axi_bvalid, s1_axi_bvalid,
  input  logic                s0_axi_bready, s1_axi_bready,
  output logic [ID_W:0]       m_axi_mem_arid, m_axi_mem_awid,
  output logic [ADDR_W-1:0]   m_axi_mem_araddr, m_axi_mem_awaddr,
  output logic [1:0]          m_axi_mem_arburst, m_axi_mem_awburst,
  output logic [3:0]          m_axi_mem_arcache, m_axi_mem_awcache,
  output logic [7:0]          m_axi_mem_arlen, m_axi_mem_awlen,
  output logic                m_axi_mem_arlock, m_axi_mem_awlock,
  output logic [2:0]          m_axi_mem_arprot, m_axi_mem_awprot,
  output logic [3:0]          m_axi_mem_arqos, m_axi_mem_awqos,
  output logic [2:0]          m_axi_mem_arsize, m_axi_mem_awsize,
  output logic                m_axi_mem_arvalid, m_axi_mem_awvalid,
  input  logic                m_axi_mem_arready, m_axi_mem_awready,
  output logic [DATA_W-1:0]   m_axi_mem_wdata,
  output logic [DATA_W/8-1:0] m_axi_mem_wstrb,
  output logic                m_axi_mem_wlast, m_axi_mem_wvalid,
  input  logic                m_axi_mem_wready,
  input  logic [ID_W:0]       m_axi_mem_rid, m_axi_mem_bid,
  input  logic [DATA_W-1:0]   m_axi_mem_rdata,
  input  logic [1:0]          m_axi_mem_rresp, m_axi_mem_bresp,
  input  logic                m_axi_mem_rlast, m_axi_mem_rvalid, m_axi_mem_bvalid,
  output logic                m_axi_mem_rready, m_axi_mem_bready
);
  localparam int P_W  = ADDR_W + 25;
  localparam int QA_W = $clog2(WQ_DEPTH);

  logic [1:0]     ar_ready, aw_ready;
  logic [P_W-1:0] ar_pay, aw_pay;

  role_mem_arbiter_addr #(.ID_W(ID_W), .P_W(P_W)) u_ar (
    .clk(aclk), .rst_n(aresetn), .en(1'b1),
    .valid({s1_axi_arvalid, s0_axi_arvalid}), .id0(s0_axi_arid), .id1(s1_axi_arid),
    .pay0({s0_axi_araddr, s0_axi_arburst, s0_axi_arcache, s0_axi_arlen, s0_axi_arlock,
           s0_axi_arprot, s0_axi_arqos, s0_axi_arsize}),
    .pay1({s1_axi_araddr, s1_axi_arburst, s1_axi_arcache, s1_axi_arlen, s1_axi_arlock,
           s1_axi_arprot, s1_axi_arqos, s1_axi_arsize}),
    .ready(ar_ready), .m_valid(m_axi_mem_arvalid), .m_ready(m_axi_mem_arready),
    .m_id(m_axi_mem_arid), .m_pay(ar_pay)
  );
  assign {s1_axi_arready, s0_axi_arready} = ar_ready;
  assign {m_axi_mem_araddr, m_axi_mem_arburst, m_axi_mem_arcache, m_axi_mem_arlen,
          m_axi_mem_arlock, m_axi_mem_arprot, m_axi_mem_arqos, m_axi_mem_arsize} = ar_pay;

  // W-order FIFO: one bit per accepted AW naming the requester whose data comes next.
  logic            wq_mem [WQ_DEPTH];
  logic [QA_W-1:0] wq_rd, wq_wr;
  logic [QA_W:0]   wq_cnt;
  logic            wq_empty, wq_full, wq_head, w_pop, aw_push;

  assign wq_empty = (wq_cnt == '0);
  assign wq_head  = wq_mem[wq_rd];
  assign w_pop    = m_axi_mem_wvalid && m_axi_mem_wready && m_axi_mem_wlast;
  assign wq_full  = (wq_cnt == (QA_W+1)'(WQ_DEPTH)) && !w_pop;
  assign aw_push  = |aw_ready;

  role_mem_arbiter_addr #(.ID_W(ID_W), .P_W(P_W)) u_aw (
    .clk(aclk), .rst_n(aresetn), .en(!wq_full),
    .valid({s1_axi_awvalid, s0_axi_awvalid}), .id0(s0_axi_awid), .id1(s1_axi_awid),
    .pay0({s0_axi_awaddr, s0_axi_awburst, s0_axi_awcache, s0_axi_awlen, s0_axi_awlock,
           s0_axi_awprot, s0_axi_awqos, s0_axi_awsize}),
    .pay1({s1_axi_awaddr, s1_axi_awburst, s1_axi_awcache, s1_axi_awlen, s1_axi_awlock,
           s1_axi_awprot, s1_axi_awqos, s1_axi_awsize}),
    .ready(aw_ready), .m_valid(m_axi_mem_awvalid), .m_ready(m_axi_mem_awready),
    .m_id(m_axi_mem_awid), .m_pay(aw_pay)
  );
  assign {s1_axi_awready, s0_axi_awready} = aw_ready;
  assign {m_axi_mem_awaddr, m_axi_mem_awburst, m_axi_mem_awcache, m_axi_mem_awlen,
          m_axi_mem_awlock, m_axi_mem_awprot, m_axi_mem_awqos, m_axi_mem_awsize} = aw_pay;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wq_rd  <= '0;
      wq_wr  <= '0;
      wq_cnt <= '0;
    end else begin
      if (aw_push) wq_wr <= wq_wr + QA_W'(1);
      if (w_pop)   wq_rd <= wq_rd + QA_W'(1);
      case ({aw_push, w_pop})
        2'b10:   wq_cnt <= wq_cnt + (QA_W+1)'(1);
        2'b01:   wq_cnt <= wq_cnt - (QA_W+1)'(1);
        default: wq_cnt <= wq_cnt;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (aw_push) wq_mem[wq_wr] <= aw_ready[1];
  end

  assign m_axi_mem_wvalid = !wq_empty && (wq_head ? s1_axi_wvalid : s0_axi_wvalid);
  assign m_axi_mem_wdata  = wq_head ? s1_axi_wdata : s0_axi_wdata;
  assign m_axi_mem_wstrb  = wq_head ? s1_axi_wstrb : s0_axi_wstrb;
  assign m_axi_mem_wlast  = wq_head ? s1_axi_wlast : s0_axi_wlast;
  assign s0_axi_wready    = !wq_empty && !wq_head && m_axi_mem_wready;
  assign s1_axi_wready    = !wq_empty &&  wq_head && m_axi_mem_wready;

  // Responses are steered purely by the requester bit the AR/AW path prepended to the ID.
  logic r_sel, b_sel;
  assign r_sel = m_axi_mem_rid[ID_W];
  assign b_sel = m_axi_mem_bid[ID_W];

  assign s0_axi_rvalid    = aresetn && m_axi_mem_rvalid && !r_sel;
  assign s1_axi_rvalid    = aresetn && m_axi_mem_rvalid &&  r_sel;
  assign m_axi_mem_rready = aresetn && (r_sel ? s1_axi_rready : s0_axi_rready);
  assign s0_axi_rid   = m_axi_mem_rid[ID_W-1:0];
  assign s1_axi_rid   = m_axi_mem_rid[ID_W-1:0];
  assign s0_axi_rdata = m_axi_mem_rdata;
  assign s1_axi_rdata = m_axi_mem_rdata;
  assign s0_axi_rresp = m_axi_mem_rresp;
  assign s1_axi_rresp = m_axi_mem_rresp;
  assign s0_axi_rlast = m_axi_mem_rlast;
  assign s1_axi_rlast = m_axi_mem_rlast;

  assign s0_axi_bvalid    = aresetn && m_axi_mem_bvalid && !b_sel;
  assign s1_axi_bvalid    = aresetn && m_axi_mem_bvalid &&  b_sel;
  assign m_axi_mem_bready = aresetn && (b_sel ? s1_axi_bready : s0_axi_bready);
  assign s0_axi_bid   = m_axi_mem_bid[ID_W-1:0];
  assign s1_axi_bid   = m_axi_mem_bid[ID_W-1:0];
  assign s0_axi_bresp = m_axi_mem_bresp;
  assign s1_axi_bresp = m_axi_mem_bresp;
endmodule

// File: tb/tb_role_mem_arbiter.sv
// Self-checking bench for role_mem_arbiter: directed scenarios plus randomized AR and
// response-routing traffic checked against a transaction-level reference model.

module tb_role_mem_arbiter;
  localparam int ID_W = 13, ADDR_W = 48, DATA_W = 256, WQ_DEPTH = 4;

  logic aclk = 1'b0, aresetn = 1'b0;
  logic [ID_W-1:0]     s0_axi_arid, s1_axi_arid, s0_axi_awid, s1_axi_awid;
  logic [ADDR_W-1:0]   s0_axi_araddr, s1_axi_araddr, s0_axi_awaddr, s1_axi_awaddr;
  logic [1:0]          s0_axi_arburst, s1_axi_arburst, s0_axi_awburst, s1_axi_awburst;
  logic [3:0]          s0_axi_arcache, s1_axi_arcache, s0_axi_awcache, s1_axi_awcache;
  logic [7:0]          s0_axi_arlen, s1_axi_arlen, s0_axi_awlen, s1_axi_awlen;
  logic                s0_axi_arlock, s1_axi_arlock, s0_axi_awlock, s1_axi_awlock;
  logic [2:0]          s0_axi_arprot, s1_axi_arprot, s0_axi_awprot, s1_axi_awprot;
  logic [3:0]          s0_axi_arqos, s1_axi_arqos, s0_axi_awqos, s1_axi_awqos;
  logic [2:0]          s0_axi_arsize, s1_axi_arsize, s0_axi_awsize, s1_axi_awsize;
  logic                s0_axi_arvalid, s1_axi_arvalid, s0_axi_awvalid, s1_axi_awvalid;
  logic                s0_axi_arready, s1_axi_arready, s0_axi_awready, s1_axi_awready;
  logic [DATA_W-1:0]   s0_axi_wdata, s1_axi_wdata;
  logic [DATA_W/8-1:0] s0_axi_wstrb, s1_axi_wstrb;
  logic                s0_axi_wlast, s1_axi_wlast, s0_axi_wvalid, s1_axi_wvalid;
  logic                s0_axi_wready, s1_axi_wready;
  logic [ID_W-1:0]     s0_axi_rid, s1_axi_rid, s0_axi_bid, s1_axi_bid;
  logic [DATA_W-1:0]   s0_axi_rdata, s1_axi_rdata;
  logic [1:0]          s0_axi_rresp, s1_axi_rresp, s0_axi_bresp, s1_axi_bresp;
  logic                s0_axi_rlast, s1_axi_rlast, s0_axi_rvalid, s1_axi_rvalid;
  logic                s0_axi_rready, s1_axi_rready, s0_axi_bvalid, s1_axi_bvalid;
  logic                s0_axi_bready, s1_axi_bready;
  logic [ID_W:0]       m_axi_mem_arid, m_axi_mem_awid, m_axi_mem_rid, m_axi_mem_bid;
  logic [ADDR_W-1:0]   m_axi_mem_araddr, m_axi_mem_awaddr;
  logic [1:0]          m_axi_mem_arburst, m_axi_mem_awburst, m_axi_mem_rresp, m_axi_mem_bresp;
  logic [3:0]          m_axi_mem_arcache, m_axi_mem_awcache, m_axi_mem_arqos, m_axi_mem_awqos;
  logic [7:0]          m_axi_mem_arlen, m_axi_mem_awlen;
  logic                m_axi_mem_arlock, m_axi_mem_awlock;
  logic [2:0]          m_axi_mem_arprot, m_axi_mem_awprot, m_axi_mem_arsize, m_axi_mem_awsize;
  logic                m_axi_mem_arvalid, m_axi_mem_awvalid, m_axi_mem_arready, m_axi_mem_awready;
  logic [DATA_W-1:0]   m_axi_mem_wdata, m_axi_mem_rdata;
  logic [DATA_W/8-1:0] m_axi_mem_wstrb;
  logic                m_axi_mem_wlast, m_axi_mem_wvalid, m_axi_mem_wready;
  logic                m_axi_mem_rlast, m_axi_mem_rvalid, m_axi_mem_rready;
  logic                m_axi_mem_bvalid, m_axi_mem_bready;

  int vecs = 0;
  int errs = 0;

  role_mem_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WQ_DEPTH(WQ_DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_axi_arid(s0_axi_arid), .s0_axi_araddr(s0_axi_araddr), .s0_axi_arburst(s0_axi_arburst),
    .s0_axi_arcache(s0_axi_arcache), .s0_axi_arlen(s0_axi_arlen), .s0_axi_arlock(s0_axi_arlock),
    .s0_axi_arprot(s0_axi_arprot), .s0_axi_arqos(s0_axi_arqos), .s0_axi_arsize(s0_axi_arsize),
    .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
    .s1_axi_arid(s1_axi_arid), .s1_axi_araddr(s1_axi_araddr), .s1_axi_arburst(s1_axi_arburst),
    .s1_axi_arcache(s1_axi_arcache), .s1_axi_arlen(s1_axi_arlen), .s1_axi_arlock(s1_axi_arlock),
    .s1_axi_arprot(s1_axi_arprot), .s1_axi_arqos(s1_axi_arqos), .s1_axi_arsize(s1_axi_arsize),
    .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
    .s0_axi_awid(s0_axi_awid), .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awburst(s0_axi_awburst),
    .s0_axi_awcache(s0_axi_awcache), .s0_axi_awlen(s0_axi_awlen), .s0_axi_awlock(s0_axi_awlock),
    .s0_axi_awprot(s0_axi_awprot), .s0_axi_awqos(s0_axi_awqos), .s0_axi_awsize(s0_axi_awsize),
    .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_awready(s0_axi_awready),
    .s1_axi_awid(s1_axi_awid), .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awburst(s1_axi_awburst),
    .s1_axi_awcache(s1_axi_awcache), .s1_axi_awlen(s1_axi_awlen), .s1_axi_awlock(s1_axi_awlock),
    .s1_axi_awprot(s1_axi_awprot), .s1_axi_awqos(s1_axi_awqos), .s1_axi_awsize(s1_axi_awsize),
    .s1_axi_awvalid(s1_axi_awvalid), .s1_axi_awready(s1_axi_awready),
    .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb), .s0_axi_wlast(s0_axi_wlast),
    .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wready(s0_axi_wready),
    .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb), .s1_axi_wlast(s1_axi_wlast),
    .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wready(s1_axi_wready),
    .s0_axi_rid(s0_axi_rid), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
    .s0_axi_rlast(s0_axi_rlast), .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
    .s1_axi_rid(s1_axi_rid), .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
    .s1_axi_rlast(s1_axi_rlast), .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
    .s0_axi_bid(s0_axi_bid), .s0_axi_bresp(s0_axi_bresp), .s0_axi_bvalid(s0_axi_bvalid),
    .s0_axi_bready(s0_axi_bready),
    .s1_axi_bid(s1_axi_bid), .s1_axi_bresp(s1_axi_bresp), .s1_axi_bvalid(s1_axi_bvalid),
    .s1_axi_bready(s1_axi_bready),
    .m_axi_mem_arid(m_axi_mem_arid), .m_axi_mem_araddr(m_axi_mem_araddr),
    .m_axi_mem_arburst(m_axi_mem_arburst), .m_axi_mem_arcache(m_axi_mem_arcache),
    .m_axi_mem_arlen(m_axi_mem_arlen), .m_axi_mem_arlock(m_axi_mem_arlock),
    .m_axi_mem_arprot(m_axi_mem_arprot), .m_axi_mem_arqos(m_axi_mem_arqos),
    .m_axi_mem_arsize(m_axi_mem_arsize), .m_axi_mem_arvalid(m_axi_mem_arvalid),
    .m_axi_mem_arready(m_axi_mem_arready),
    .m_axi_mem_awid(m_axi_mem_awid), .m_axi_mem_awaddr(m_axi_mem_awaddr),
    .m_axi_mem_awburst(m_axi_mem_awburst), .m_axi_mem_awcache(m_axi_mem_awcache),
    .m_axi_mem_awlen(m_axi_mem_awlen), .m_axi_mem_awlock(m_axi_mem_awlock),
    .m_axi_mem_awprot(m_axi_mem_awprot), .m_axi_mem_awqos(m_axi_mem_awqos),
    .m_axi_mem_awsize(m_axi_mem_awsize), .m_axi_mem_awvalid(m_axi_mem_awvalid),
    .m_axi_mem_awready(m_axi_mem_awready),
    .m_axi_mem_wdata(m_axi_mem_wdata), .m_axi_mem_wstrb(m_axi_mem_wstrb),
    .m_axi_mem_wlast(m_axi_mem_wlast), .m_axi_mem_wvalid(m_axi_mem_wvalid),
    .m_axi_mem_wready(m_axi_mem_wready),
    .m_axi_mem_rid(m_axi_mem_rid), .m_axi_mem_rdata(m_axi_mem_rdata),
    .m_axi_mem_rresp(m_axi_mem_rresp), .m_axi_mem_rlast(m_axi_mem_rlast),
    .m_axi_mem_rvalid(m_axi_mem_rvalid), .m_axi_mem_rready(m_axi_mem_rready),
    .m_axi_mem_bid(m_axi_mem_bid), .m_axi_mem_bresp(m_axi_mem_bresp),
    .m_axi_mem_bvalid(m_axi_mem_bvalid), .m_axi_mem_bready(m_axi_mem_bready)
  );

  always #5 aclk = ~aclk;

  // Every valid/ready output the block drives; all must read zero while in reset.
  logic [14:0] all_vr;
  assign all_vr = {m_axi_mem_arvalid, m_axi_mem_awvalid, m_axi_mem_wvalid,
                   s0_axi_arready, s1_axi_arready, s0_axi_awready, s1_axi_awready,
                   s0_axi_wready, s1_axi_wready, s0_axi_rvalid, s1_axi_rvalid,
                   s0_axi_bvalid, s1_axi_bvalid, m_axi_mem_rready, m_axi_mem_bready};

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    {s0_axi_arid, s1_axi_arid, s0_axi_awid, s1_axi_awid} = '0;
    {s0_axi_araddr, s1_axi_araddr, s0_axi_awaddr, s1_axi_awaddr} = '0;
    {s0_axi_arburst, s1_axi_arburst, s0_axi_awburst, s1_axi_awburst} = '0;
    {s0_axi_arcache, s1_axi_arcache, s0_axi_awcache, s1_axi_awcache} = '0;
    {s0_axi_arlen, s1_axi_arlen, s0_axi_awlen, s1_axi_awlen} = '0;
    {s0_axi_arlock, s1_axi_arlock, s0_axi_awlock, s1_axi_awlock} = '0;
    {s0_axi_arprot, s1_axi_arprot, s0_axi_awprot, s1_axi_awprot} = '0;
    {s0_axi_arqos, s1_axi_arqos, s0_axi_awqos, s1_axi_awqos} = '0;
    {s0_axi_arsize, s1_axi_arsize, s0_axi_awsize, s1_axi_awsize} = '0;
    {s0_axi_arvalid, s1_axi_arvalid, s0_axi_awvalid, s1_axi_awvalid} = '0;
    {s0_axi_wdata, s1_axi_wdata, s0_axi_wstrb, s1_axi_wstrb} = '0;
    {s0_axi_wlast, s1_axi_wlast, s0_axi_wvalid, s1_axi_wvalid} = '0;
    {s0_axi_rready, s1_axi_rready, s0_axi_bready, s1_axi_bready} = '0;
    {m_axi_mem_arready, m_axi_mem_awready, m_axi_mem_wready} = '0;
    {m_axi_mem_rid, m_axi_mem_rdata, m_axi_mem_rresp, m_axi_mem_rlast, m_axi_mem_rvalid} = '0;
    {m_axi_mem_bid, m_axi_mem_bresp, m_axi_mem_bvalid} = '0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear_inputs();
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    clear_inputs();
    {s0_axi_arvalid, s1_axi_awvalid, m_axi_mem_rvalid, m_axi_mem_bvalid} = '1;
    {m_axi_mem_arready, m_axi_mem_awready, s0_axi_rready, s1_axi_bready} = '1;
    tick();
    tick();
    vecs++;
    if (all_vr !== '0) begin errs++; $display("FAIL reset_held got %b want 0", all_vr); end
    clear_inputs();
    aresetn = 1'b1;
    tick();
    vecs++;
    if (all_vr !== '0) begin errs++; $display("FAIL reset_release got %b want 0", all_vr); end
  endtask

  task automatic test_single_read();
    logic [DATA_W-1:0] d;
    d = {8{$urandom}};
    m_axi_mem_arready = 1'b1;
    s1_axi_arvalid = 1'b1; s1_axi_arid = 13'h5; s1_axi_araddr = 48'h1000;
    #1;
    vecs++;
    if ({s1_axi_arready, s0_axi_arready} !== 2'b10) begin
      errs++; $display("FAIL single_arready got %b want 10", {s1_axi_arready, s0_axi_arready});
    end
    tick();
    s1_axi_arvalid = 1'b0;
    vecs++;
    if (m_axi_mem_arvalid !== 1'b1 || m_axi_mem_arid !== 14'h2005 || m_axi_mem_araddr !== 48'h1000) begin
      errs++; $display("FAIL single_m_ar got v=%b id=%h a=%h want v=1 id=2005 a=1000",
                       m_axi_mem_arvalid, m_axi_mem_arid, m_axi_mem_araddr);
    end
    tick();
    vecs++;
    if (m_axi_mem_arvalid !== 1'b0) begin errs++; $display("FAIL single_drain got 1 want 0"); end
    m_axi_mem_rvalid = 1'b1; m_axi_mem_rid = 14'h2005; m_axi_mem_rdata = d; m_axi_mem_rlast = 1'b1;
    s1_axi_rready = 1'b1;
    #1;
    vecs++;
    if ({s1_axi_rvalid, s0_axi_rvalid} !== 2'b10 || s1_axi_rid !== 13'h5 || s1_axi_rdata !== d ||
        s1_axi_rlast !== 1'b1 || m_axi_mem_rready !== 1'b1) begin
      errs++; $display("FAIL single_r got rv=%b rid=%h last=%b rr=%b want rv=10 rid=5 last=1 rr=1",
                       {s1_axi_rvalid, s0_axi_rvalid}, s1_axi_rid, s1_axi_rlast, m_axi_mem_rready);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_contention();
    do_reset();
    m_axi_mem_arready = 1'b1;
    s0_axi_arvalid = 1'b1; s0_axi_arid = 13'h10;
    s1_axi_arvalid = 1'b1; s1_axi_arid = 13'h20;
    for (int i = 0; i < 4; i++) begin
      logic w;
      w = 1'(i % 2);
      #1;
      vecs++;
      if ({s1_axi_arready, s0_axi_arready} !== (w ? 2'b10 : 2'b01)) begin
        errs++; $display("FAIL contention_grant%0d got %b want s%0d", i,
                         {s1_axi_arready, s0_axi_arready}, w);
      end
      tick();
      vecs++;
      if (m_axi_mem_arvalid !== 1'b1 || m_axi_mem_arid !== {w, w ? 13'h20 : 13'h10}) begin
        errs++; $display("FAIL contention_m%0d got v=%b id=%h", i, m_axi_mem_arvalid, m_axi_mem_arid);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    s0_axi_arvalid = 1'b1; s0_axi_arid = 13'h1; s0_axi_araddr = 48'h2000; s0_axi_arlen = 8'd7;
    s1_axi_arvalid = 1'b1; s1_axi_arid = 13'h2; s1_axi_araddr = 48'h3000;
    #1;
    vecs++;
    if ({s1_axi_arready, s0_axi_arready} !== 2'b01) begin
      errs++; $display("FAIL bp_first got %b want 01", {s1_axi_arready, s0_axi_arready});
    end
    tick();
    s0_axi_araddr = 48'h2040; s0_axi_arlen = 8'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      vecs++;
      if (m_axi_mem_arvalid !== 1'b1 || m_axi_mem_araddr !== 48'h2000 || m_axi_mem_arid !== 14'h0001 ||
          m_axi_mem_arlen !== 8'd7 || {s1_axi_arready, s0_axi_arready} !== 2'b00) begin
        errs++; $display("FAIL bp_stall%0d got v=%b a=%h id=%h rdy=%b", k, m_axi_mem_arvalid,
                         m_axi_mem_araddr, m_axi_mem_arid, {s1_axi_arready, s0_axi_arready});
      end
      tick();
    end
    m_axi_mem_arready = 1'b1;
    #1;
    vecs++;
    if ({s1_axi_arready, s0_axi_arready} !== 2'b10) begin
      errs++; $display("FAIL bp_resume got %b want 10", {s1_axi_arready, s0_axi_arready});
    end
    tick();
    vecs++;
    if (m_axi_mem_araddr !== 48'h3000 || m_axi_mem_arid !== 14'h2002) begin
      errs++; $display("FAIL bp_next got a=%h id=%h want a=3000 id=2002", m_axi_mem_araddr, m_axi_mem_arid);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_write_order();
    logic [DATA_W-1:0] d0, d1a, d1b;
    d0 = {8{$urandom}}; d1a = {8{$urandom}}; d1b = {8{$urandom}};
    do_reset();
    m_axi_mem_awready = 1'b1; m_axi_mem_wready = 1'b1;
    s1_axi_awvalid = 1'b1; s1_axi_awid = 13'h7; s1_axi_awlen = 8'd1;
    tick();
    s1_axi_awvalid = 1'b0;
    s0_axi_awvalid = 1'b1; s0_axi_awid = 13'h3; s0_axi_awlen = 8'd0;
    s0_axi_wvalid = 1'b1; s0_axi_wdata = d0; s0_axi_wlast = 1'b1;
    #1;
    vecs++;
    if (m_axi_mem_awid !== 14'h2007 || s0_axi_awready !== 1'b1 || s0_axi_wready !== 1'b0 ||
        m_axi_mem_wvalid !== 1'b0) begin
      errs++; $display("FAIL wo_aw got awid=%h awrdy0=%b wrdy0=%b mwv=%b", m_axi_mem_awid,
                       s0_axi_awready, s0_axi_wready, m_axi_mem_wvalid);
    end
    tick();
    s0_axi_awvalid = 1'b0;
    s1_axi_wvalid = 1'b1; s1_axi_wdata = d1a; s1_axi_wlast = 1'b0;
    #1;
    vecs++;
    if (m_axi_mem_wvalid !== 1'b1 || m_axi_mem_wdata !== d1a || m_axi_mem_wlast !== 1'b0 ||
        s1_axi_wready !== 1'b1 || s0_axi_wready !== 1'b0) begin
      errs++; $display("FAIL wo_s1_beat0 got mwv=%b wl=%b wr1=%b wr0=%b", m_axi_mem_wvalid,
                       m_axi_mem_wlast, s1_axi_wready, s0_axi_wready);
    end
    tick();
    s1_axi_wdata = d1b; s1_axi_wlast = 1'b1;
    #1;
    vecs++;
    if (m_axi_mem_wdata !== d1b || m_axi_mem_wlast !== 1'b1 || s0_axi_wready !== 1'b0) begin
      errs++; $display("FAIL wo_s1_beat1 got wl=%b wr0=%b", m_axi_mem_wlast, s0_axi_wready);
    end
    tick();
    s1_axi_wvalid = 1'b0;
    #1;
    vecs++;
    if (s0_axi_wready !== 1'b1 || m_axi_mem_wdata !== d0 || m_axi_mem_wlast !== 1'b1 ||
        m_axi_mem_wvalid !== 1'b1) begin
      errs++; $display("FAIL wo_s0_beat got wr0=%b mwv=%b wl=%b", s0_axi_wready,
                       m_axi_mem_wvalid, m_axi_mem_wlast);
    end
    tick();
    s0_axi_wvalid = 1'b0;
    #1;
    vecs++;
    if (m_axi_mem_wvalid !== 1'b0 || s0_axi_wready !== 1'b0) begin
      errs++; $display("FAIL wo_empty got mwv=%b wr0=%b want 0 0", m_axi_mem_wvalid, s0_axi_wready);
    end
    m_axi_mem_bvalid = 1'b1; m_axi_mem_bid = 14'h2007; s1_axi_bready = 1'b1;
    #1;
    vecs++;
    if ({s1_axi_bvalid, s0_axi_bvalid} !== 2'b10 || s1_axi_bid !== 13'h7 || m_axi_mem_bready !== 1'b1) begin
      errs++; $display("FAIL wo_b1 got bv=%b bid=%h br=%b", {s1_axi_bvalid, s0_axi_bvalid},
                       s1_axi_bid, m_axi_mem_bready);
    end
    m_axi_mem_bid = 14'h0003;
    #1;
    vecs++;
    if ({s1_axi_bvalid, s0_axi_bvalid} !== 2'b01 || s0_axi_bid !== 13'h3 || m_axi_mem_bready !== 1'b0) begin
      errs++; $display("FAIL wo_b0 got bv=%b bid=%h br=%b", {s1_axi_bvalid, s0_axi_bvalid},
                       s0_axi_bid, m_axi_mem_bready);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_fifo_full();
    do_reset();
    m_axi_mem_awready = 1'b1; m_axi_mem_wready = 1'b1;
    s0_axi_awvalid = 1'b1;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      s0_axi_awid = ID_W'(i);
      #1;
      vecs++;
      if (s0_axi_awready !== 1'b1) begin errs++; $display("FAIL full_accept%0d got 0 want 1", i); end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      vecs++;
      if (s0_axi_awready !== 1'b0) begin errs++; $display("FAIL full_block%0d got 1 want 0", k); end
      tick();
    end
    s0_axi_wvalid = 1'b1; s0_axi_wlast = 1'b1;
    #1;
    vecs++;
    if (s0_axi_awready !== 1'b1 || s0_axi_wready !== 1'b1) begin
      errs++; $display("FAIL full_pop_push got awr=%b wr=%b want 1 1", s0_axi_awready, s0_axi_wready);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    m_axi_mem_awready = 1'b1; m_axi_mem_wready = 1'b1;
    s1_axi_awvalid = 1'b1; s1_axi_awlen = 8'd3;
    tick();
    s1_axi_awvalid = 1'b0;
    s1_axi_wvalid = 1'b1; s1_axi_wlast = 1'b0;
    #1;
    vecs++;
    if (m_axi_mem_wvalid !== 1'b1) begin errs++; $display("FAIL ar_midburst got 0 want 1"); end
    {s1_axi_awvalid, s0_axi_arvalid, m_axi_mem_arready, m_axi_mem_rvalid, s0_axi_rready} = '1;
    #2;
    aresetn = 1'b0;
    #1;
    vecs++;
    if (all_vr !== '0) begin errs++; $display("FAIL ar_immediate got %b want 0", all_vr); end
    clear_inputs();
    tick();
    tick();
    aresetn = 1'b1;
    s0_axi_wvalid = 1'b1; s1_axi_wvalid = 1'b1; m_axi_mem_wready = 1'b1;
    #1;
    vecs++;
    if ({m_axi_mem_wvalid, s1_axi_wready, s0_axi_wready} !== 3'b000) begin
      errs++; $display("FAIL ar_fifo_empty got %b want 000", {m_axi_mem_wvalid, s1_axi_wready, s0_axi_wready});
    end
    s0_axi_arvalid = 1'b1; s1_axi_arvalid = 1'b1; m_axi_mem_arready = 1'b1;
    #1;
    vecs++;
    if ({s1_axi_arready, s0_axi_arready} !== 2'b01) begin
      errs++; $display("FAIL ar_ptr got %b want 01", {s1_axi_arready, s0_axi_arready});
    end
    clear_inputs();
    tick();
  endtask

  // Transaction-level model: one pending master request at most; round-robin favours the
  // requester not served last whenever both ask at once.
  task automatic test_random_ar();
    bit pending, favour, v0, v1, rdy, win, go;
    logic [ID_W:0]   exp_id;
    logic [ADDR_W-1:0] exp_addr;
    do_reset();
    pending = 1'b0; favour = 1'b0; exp_id = '0; exp_addr = '0;
    for (int i = 0; i < 60; i++) begin
      v0 = 1'($urandom); v1 = 1'($urandom); rdy = 1'($urandom);
      s0_axi_arvalid = v0; s1_axi_arvalid = v1; m_axi_mem_arready = rdy;
      s0_axi_arid = ID_W'($urandom); s1_axi_arid = ID_W'($urandom);
      s0_axi_araddr = {16'h0, 32'($urandom)}; s1_axi_araddr = {16'h1, 32'($urandom)};
      #1;
      go  = (!pending || rdy) && (v0 || v1);
      win = (v0 && v1) ? favour : v1;
      vecs++;
      if ({s1_axi_arready, s0_axi_arready} !== {go && win, go && !win}) begin
        errs++; $display("FAIL rand_ar_grant%0d got %b want %b", i,
                         {s1_axi_arready, s0_axi_arready}, {go && win, go && !win});
      end
      if (go) begin
        exp_id   = {win, win ? s1_axi_arid : s0_axi_arid};
        exp_addr = win ? s1_axi_araddr : s0_axi_araddr;
        pending  = 1'b1;
        favour   = !win;
      end else if (rdy) begin
        pending = 1'b0;
      end
      tick();
      vecs++;
      if (m_axi_mem_arvalid !== pending || (pending && (m_axi_mem_arid !== exp_id ||
          m_axi_mem_araddr !== exp_addr))) begin
        errs++; $display("FAIL rand_ar_m%0d got v=%b id=%h a=%h want v=%b id=%h a=%h", i,
                         m_axi_mem_arvalid, m_axi_mem_arid, m_axi_mem_araddr, pending, exp_id, exp_addr);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random_resp();
    bit rv, rs, bv, bs;
    for (int i = 0; i < 30; i++) begin
      rv = 1'($urandom); rs = 1'($urandom); bv = 1'($urandom); bs = 1'($urandom);
      m_axi_mem_rvalid = rv; m_axi_mem_rid = {rs, ID_W'($urandom)}; m_axi_mem_rresp = 2'($urandom);
      m_axi_mem_bvalid = bv; m_axi_mem_bid = {bs, ID_W'($urandom)}; m_axi_mem_bresp = 2'($urandom);
      {s0_axi_rready, s1_axi_rready, s0_axi_bready, s1_axi_bready} = 4'($urandom);
      #1;
      vecs++;
      if ({s1_axi_rvalid, s0_axi_rvalid} !== (rv ? (rs ? 2'b10 : 2'b01) : 2'b00) ||
          m_axi_mem_rready !== (rs ? s1_axi_rready : s0_axi_rready) ||
          s0_axi_rid !== m_axi_mem_rid[ID_W-1:0] || s1_axi_rresp !== m_axi_mem_rresp) begin
        errs++; $display("FAIL rand_r%0d got rv=%b rr=%b", i, {s1_axi_rvalid, s0_axi_rvalid}, m_axi_mem_rready);
      end
      vecs++;
      if ({s1_axi_bvalid, s0_axi_bvalid} !== (bv ? (bs ? 2'b10 : 2'b01) : 2'b00) ||
          m_axi_mem_bready !== (bs ? s1_axi_bready : s0_axi_bready) ||
          s1_axi_bid !== m_axi_mem_bid[ID_W-1:0] || s0_axi_bresp !== m_axi_mem_bresp) begin
        errs++; $display("FAIL rand_b%0d got bv=%b br=%b", i, {s1_axi_bvalid, s0_axi_bvalid}, m_axi_mem_bready);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_backpressure();
    test_write_order();
    test_fifo_full();
    test_async_reset();
    test_random_ar();
    test_random_resp();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d vectors", vecs);
    $fatal(1);
  end
endmodule

// File: doc/role_mem_arbiter.md
Name: role_mem_arbiter

Overview:
- 2:1 round-robin AXI4 arbiter that shares the role's single 256-bit memory master port (m_axi_mem_*) between two internal requesters, s0 and s1. Typical requesters are an accelerator datapath and the trace/DMA engine.
- Each requester's ID is widened by one bit, and the MSB carries the requester index. R and B responses are routed back by that bit.
- The W channel follows AW grant order through a small order FIFO.

Parameters:
- ID_W, 13, requester ID width. Master ID width is ID_W+1 = 14.
- ADDR_W, 48, address width.
- DATA_W, 256, data width. Strobe width is DATA_W/8.
- WQ_DEPTH, 4, W-order FIFO depth (power of 2, ≥2).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; asynchronous, active-low.
- s{0,1}_axi_ar{id,addr,burst,cache,len,lock,prot,qos,size,valid}  in  ID_W/ADDR_W/2/4/8/1/3/4/3/1  requester read address.
- s{0,1}_axi_arready  out  1.
- s{0,1}_axi_aw{id,addr,burst,cache,len,lock,prot,qos,size,valid}  in  same widths as AR  requester write address.
- s{0,1}_axi_awready  out  1.
- s{0,1}_axi_w{data,strb,last,valid}  in  DATA_W/DATA_W/8/1/1.
- s{0,1}_axi_wready  out  1.
- s{0,1}_axi_{rid,rdata,rresp,rlast,rvalid}  out  ID_W/DATA_W/2/1/1.
- s{0,1}_axi_rready  in  1.
- s{0,1}_axi_{bid,bresp,bvalid}  out  ID_W/2/1.
- s{0,1}_axi_bready  in  1.
- m_axi_mem_ar*, m_axi_mem_aw*  out  as requester, but id is ID_W+1; *ready in.
- m_axi_mem_w{data,strb,last,valid}  out; m_axi_mem_wready in.
- m_axi_mem_{rid,rdata,rresp,rlast,rvalid}  in; m_axi_mem_rready out.
- m_axi_mem_{bid,bresp,bvalid}  in; m_axi_mem_bready out.

Behaviour:
- Reset (async assert, sync release): all valid and ready outputs 0, both round-robin pointers select s0, W-order FIFO empty, AR/AW holding registers empty.

AR channel:
- One-entry output holding register drives m_axi_mem_ar*. Slot is free when empty, or when full with m_axi_mem_arready=1 this cycle.
- When the slot is free and at least one sN_arvalid is high, grant one requester:
  - both valid: grant the pointer's requester;
  - otherwise grant the single valid one.
- sN_arready=1 only for the granted requester in that cycle. On the handshake, load fields with arid = {N, sN_arid}.
- After each grant, the pointer moves to the other requester.
- Latency: s-side handshake to m_axi_mem_arvalid is 1 cycle. Full throughput: 1 grant/cycle while m_axi_mem_arready=1.
- m_axi_mem_ar* stays stable while valid and not ready (AXI rule).

AW channel:
- Same structure as AR, with its own independent pointer.
- Grant additionally requires the W-order FIFO not full.
- On the handshake, push N into the FIFO.
- AW full and FIFO full in the same cycle, with a W pop in that cycle, is still not full: push is allowed (pop-before-push accounting).

W channel (combinational, no added latency):
- FIFO empty: m_axi_mem_wvalid=0 and both sN_wready=0. W data for a not-yet-granted AW is blocked.
- FIFO head = h:
  - m_axi_mem_w* = sh_axi_w*;
  - sh_wready = m_axi_mem_wready;
  - the other requester's wready = 0.
- Pop on m_axi_mem_wvalid & m_axi_mem_wready & wlast.
- W may arrive in the same cycle as its AW grant is pushed. It is forwarded once the entry is at the head (next cycle at earliest).

R channel (combinational):
- sN_rvalid = m_axi_mem_rvalid & (rid[ID_W]==N).
- m_axi_mem_rready = rready of the selected requester.
- rid to requester = rid[ID_W-1:0]; data, resp and last pass through.

B channel: same routing as R, using bid[ID_W].

Other:
- No outstanding-transaction limit; ordering is per ID, preserved by the memory side.
- Mid-burst reset: all state is discarded; the system resets the memory side together with the arbiter.

Test Plan:
1. Single read:
   - Stimulus: s1 ARs addr=0x1000, id=0x5.
   - Required: next cycle m arvalid=1, arid=0x2005, addr=0x1000.
   - Then m R with rid=0x2005, rlast=1 appears only on s1 with rid=0x5.
2. Contention:
   - Stimulus: s0 and s1 both hold arvalid for 4 cycles; m arready=1.
   - Required: grants in order s0, s1, s0, s1 (pointer starts at s0 after reset); one arvalid per cycle, no bubbles.
3. Backpressure:
   - Stimulus: m arready=0 for 3 cycles with arvalid held.
   - Required: m_axi_mem_ar* unchanged across the stall; both sN_arready=0; grant resumes on the cycle arready=1.
4. Write ordering:
   - Stimulus: s1 AW len=1, then s0 AW len=0; s0 presents W first.
   - Required: s0_wready=0 until s1's 2 beats (second with wlast) complete; then s0's 1 beat passes.
   - B responses with bid MSB 1 and 0 are routed to s1 and s0.
5. FIFO full:
   - Stimulus: WQ_DEPTH=4; issue 5 AWs with no W.
   - Required: 4 accepted, 5th awready=0 until the first wlast pop; accepted in that pop cycle.
6. Async reset:
   - Stimulus: assert aresetn=0 mid W burst.
   - Required: all valid/ready outputs 0 immediately (before the next edge); after release FIFO is empty and the pointer selects s0.
